// File: rtl/pc_sequencer.sv
// Next-PC controller: chooses the PC register's next address and write enable,
// and keeps the EPC/cause/EXL exception state and two performance counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
  parameter int          CNT_W      = 32
) (
  input  logic             pc_clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic [31:0]      npc,
  input  logic             branch_taken,
  input  logic [31:0]      branch_off,
  input  logic             jump,
  input  logic [25:0]      jidx,
  input  logic             jr,
  input  logic [31:0]      rs_val,
  input  logic             stall_req,
  input  logic             exc_req,
  input  logic [4:0]       exc_cause,
  input  logic             eret,
  output logic [31:0]      mux1out,
  output logic             pc_we,
  output logic [31:0]      epc,
  output logic [31:0]      cause,
  output logic             exl,
  output logic             exc_ack,
  output logic             exc_lost,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      epc_q, epc_d;
  logic [4:0]       cause_q, cause_d;
  logic             exl_q, exl_d;
  logic             lost_q, lost_d;
  logic [CNT_W-1:0] instr_cnt_q, stall_cnt_q;
  logic [31:0]      flow_pc;

  // Ordinary control flow, used both from RUN and when a stall releases.
  function automatic logic [31:0] flow_target(
    input logic        jr_f,
    input logic [31:0] rs_f,
    input logic        jump_f,
    input logic [31:0] pc_f,
    input logic [25:0] jidx_f,
    input logic        br_f,
    input logic [31:0] npc_f,
    input logic [31:0] off_f
  );
    if (jr_f)
      return rs_f;
    else if (jump_f)
      return {pc_f[31:28], jidx_f, 2'b00};
    else if (br_f)
      return npc_f + off_f;
    else
      return npc_f;
  endfunction

  assign flow_pc = flow_target(jr, rs_val, jump, pc, jidx, branch_taken, npc, branch_off);

  always_comb begin
    state_d = state_q;
    mux1out = npc;
    pc_we   = 1'b1;
    exc_ack = 1'b0;
    epc_d   = epc_q;
    cause_d = cause_q;
    exl_d   = exl_q;
    lost_d  = lost_q;
    case (state_q)
      BOOT: begin
        mux1out = RESET_PC;
        state_d = RUN;
      end
      STALL: begin
        // Exceptions and eret are not sampled while the held instruction waits.
        if (stall_req) begin
          mux1out = pc;
          pc_we   = 1'b0;
        end else begin
          mux1out = flow_pc;
          state_d = RUN;
        end
      end
      RUN: begin
        if (exc_req && !exl_q) begin
          mux1out = EXC_VECTOR;
          exc_ack = 1'b1;
          epc_d   = pc;
          cause_d = exc_cause;
          exl_d   = 1'b1;
        end else begin
          if (exc_req)
            lost_d = 1'b1;
          if (eret) begin
            mux1out = epc_q;
            exl_d   = 1'b0;
          end else if (stall_req) begin
            mux1out = pc;
            pc_we   = 1'b0;
            state_d = STALL;
          end else begin
            mux1out = flow_pc;
          end
        end
      end
      default: begin
        mux1out = RESET_PC;
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge pc_clk) begin
    if (reset) begin
      state_q     <= BOOT;
      epc_q       <= '0;
      cause_q     <= '0;
      exl_q       <= 1'b0;
      lost_q      <= 1'b0;
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      exl_q   <= exl_d;
      lost_q  <= lost_d;
      if (pc_we)
        instr_cnt_q <= instr_cnt_q + CNT_ONE;
      else
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

  assign epc       = epc_q;
  assign cause     = {25'd0, cause_q, 2'b00};
  assign exl       = exl_q;
  assign exc_lost  = lost_q;
  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_sequencer;

  localparam int S_MUX   = 0;
  localparam int S_WE    = 1;
  localparam int S_ACK   = 2;
  localparam int S_EPC   = 3;
  localparam int S_CAUSE = 4;
  localparam int S_EXL   = 5;
  localparam int S_LOST  = 6;
  localparam int S_ICNT  = 7;
  localparam int S_SCNT  = 8;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic        pc_clk;
  logic        reset;
  logic [31:0] pc, npc, branch_off, rs_val;
  logic        branch_taken, jump, jr, stall_req, exc_req, eret;
  logic [25:0] jidx;
  logic [4:0]  exc_cause;
  logic [31:0] mux1out, epc, cause, instr_cnt, stall_cnt;
  logic        pc_we, exl, exc_ack, exc_lost;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  pc_sequencer dut (
    .pc_clk      (pc_clk),
    .reset       (reset),
    .pc          (pc),
    .npc         (npc),
    .branch_taken(branch_taken),
    .branch_off  (branch_off),
    .jump        (jump),
    .jidx        (jidx),
    .jr          (jr),
    .rs_val      (rs_val),
    .stall_req   (stall_req),
    .exc_req     (exc_req),
    .exc_cause   (exc_cause),
    .eret        (eret),
    .mux1out     (mux1out),
    .pc_we       (pc_we),
    .epc         (epc),
    .cause       (cause),
    .exl         (exl),
    .exc_ack     (exc_ack),
    .exc_lost    (exc_lost),
    .instr_cnt   (instr_cnt),
    .stall_cnt   (stall_cnt)
  );

  initial pc_clk = 1'b0;
  always #5 pc_clk = ~pc_clk;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_MUX:   return mux1out;
      S_WE:    return {31'd0, pc_we};
      S_ACK:   return {31'd0, exc_ack};
      S_EPC:   return epc;
      S_CAUSE: return cause;
      S_EXL:   return {31'd0, exl};
      S_LOST:  return {31'd0, exc_lost};
      S_ICNT:  return instr_cnt;
      S_SCNT:  return stall_cnt;
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
  always @(negedge pc_clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      n_cmp++;
      if (actual(cur.sel) !== cur.val) begin
        n_bad++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", cur.name, actual(cur.sel), cur.val);
      end
    end
  end

  task automatic expect_v(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge pc_clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] p);
    pc  = p;
    npc = p + 32'd4;
  endtask

  task automatic clr();
    branch_taken = 1'b0;
    branch_off   = '0;
    jump         = 1'b0;
    jidx         = '0;
    jr           = 1'b0;
    rs_val       = '0;
    stall_req    = 1'b0;
    exc_req      = 1'b0;
    exc_cause    = '0;
    eret         = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    set_pc(32'h0);
    step();
    step();

    // Boot cycle
    reset = 1'b0;
    expect_v("boot_mux", S_MUX, 32'h0);
    expect_v("boot_we", S_WE, 32'd1);
    expect_v("rst_icnt", S_ICNT, 32'd0);
    expect_v("rst_scnt", S_SCNT, 32'd0);
    expect_v("rst_epc", S_EPC, 32'd0);
    expect_v("rst_cause", S_CAUSE, 32'd0);
    expect_v("rst_exl", S_EXL, 32'd0);
    expect_v("rst_lost", S_LOST, 32'd0);

    // Sequential flow
    step(); set_pc(32'h0);
    expect_v("seq_mux0", S_MUX, 32'h4);
    expect_v("seq_we0", S_WE, 32'd1);
    step(); set_pc(32'h4);
    expect_v("seq_mux1", S_MUX, 32'h8);
    step(); set_pc(32'h8);
    expect_v("seq_mux2", S_MUX, 32'hC);

    // Jump beats branch
    step(); set_pc(32'h0040_0010);
    expect_v("icnt_4", S_ICNT, 32'd4);
    branch_taken = 1'b1; branch_off = 32'h40; jump = 1'b1; jidx = 26'h0000100;
    expect_v("jump_pri", S_MUX, 32'h0000_0400);

    // Taken branch with negative offset
    step(); clr(); set_pc(32'h100);
    branch_taken = 1'b1; branch_off = 32'hFFFF_FFF0;
    expect_v("branch_neg", S_MUX, 32'h0000_00F4);

    // Stall for 3 cycles, then jr
    step(); clr(); set_pc(32'h20);
    stall_req = 1'b1; jr = 1'b1; rs_val = 32'h100;
    expect_v("stall0_mux", S_MUX, 32'h20);
    expect_v("stall0_we", S_WE, 32'd0);
    step();
    expect_v("stall1_mux", S_MUX, 32'h20);
    expect_v("stall1_we", S_WE, 32'd0);
    step();
    expect_v("stall2_we", S_WE, 32'd0);
    step(); stall_req = 1'b0;
    expect_v("stall_cnt3", S_SCNT, 32'd3);
    expect_v("jr_release", S_MUX, 32'h100);
    expect_v("jr_we", S_WE, 32'd1);

    // Exception outranks a simultaneous stall
    step(); clr(); set_pc(32'h30);
    expect_v("icnt_7", S_ICNT, 32'd7);
    exc_req = 1'b1; exc_cause = 5'd8; stall_req = 1'b1;
    expect_v("exc_mux", S_MUX, 32'h4);
    expect_v("exc_ack", S_ACK, 32'd1);
    expect_v("exc_we", S_WE, 32'd1);

    // Nested request is dropped
    step(); clr(); set_pc(32'h4);
    expect_v("epc_30", S_EPC, 32'h30);
    expect_v("cause_8", S_CAUSE, 32'h20);
    expect_v("exl_set", S_EXL, 32'd1);
    exc_req = 1'b1; exc_cause = 5'd3;
    expect_v("nest_mux", S_MUX, 32'h8);
    expect_v("nest_ack", S_ACK, 32'd0);

    // eret returns to EPC
    step(); clr(); set_pc(32'h8);
    expect_v("lost_set", S_LOST, 32'd1);
    expect_v("cause_kept", S_CAUSE, 32'h20);
    eret = 1'b1;
    expect_v("eret_mux", S_MUX, 32'h30);

    // Re-enter the handler
    step(); clr(); set_pc(32'h50);
    expect_v("exl_clr", S_EXL, 32'd0);
    expect_v("lost_sticky", S_LOST, 32'd1);
    exc_req = 1'b1; exc_cause = 5'd13;
    expect_v("exc2_mux", S_MUX, 32'h4);

    // Stall inside the handler
    step(); clr(); set_pc(32'h4);
    expect_v("epc_50", S_EPC, 32'h50);
    expect_v("cause_13", S_CAUSE, 32'h34);
    stall_req = 1'b1;
    expect_v("hstall_we", S_WE, 32'd0);

    // In STALL an exception request is ignored; reset asserted here
    step();
    expect_v("scnt_4", S_SCNT, 32'd4);
    exc_req = 1'b1;
    expect_v("stall_noack", S_ACK, 32'd0);
    expect_v("stall_mux", S_MUX, 32'h4);
    reset = 1'b1;

    // Back in BOOT with everything cleared
    step(); clr(); reset = 1'b0; set_pc(32'h10);
    expect_v("rst2_mux", S_MUX, 32'h0);
    expect_v("rst2_exl", S_EXL, 32'd0);
    expect_v("rst2_scnt", S_SCNT, 32'd0);
    expect_v("rst2_lost", S_LOST, 32'd0);
    expect_v("rst2_epc", S_EPC, 32'd0);
    expect_v("rst2_icnt", S_ICNT, 32'd0);

    // eret with exl=0 still redirects to EPC (now 0)
    step(); eret = 1'b1;
    expect_v("eret0_mux", S_MUX, 32'h0);
    expect_v("icnt_1", S_ICNT, 32'd1);

    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge pc_clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
